fir_wb_sched: RTL

- Wishbone-slave front end in the user project area that sequences the FIR engine for the management CPU.
- Decodes CPU Wishbone cycles in the user address window into FIR AXI-Lite config transactions, AXI-Stream X pushes and Y pops, and a local status register.
- Generates ss_tlast from a snooped data_length.
- Serialises all accesses: one outstanding Wishbone cycle, one FIR-side transaction at a time.

---
 rtl/fir_wb_pkg.sv | 36 +++
 rtl/fir_wb_tlast_gen.sv | 43 ++++
 rtl/fir_wb_sched.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_wb_pkg.sv
// Shared types and constants for the FIR Wishbone sequencer.
package fir_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG_WR,
    CFG_RD,
    X_PUSH,
    Y_POP,
    ACK
  } state_e;

  localparam logic [7:0] X_OFF   = 8'h80;
  localparam logic [7:0] Y_OFF   = 8'h84;
  localparam logic [7:0] ST_OFF  = 8'h88;
  localparam logic [7:0] LEN_OFF = 8'h10;
  localparam logic [7:0] AP_OFF  = 8'h00;

  localparam int ST_ERR_BIT   = 0;
  localparam int ST_YSEEN_BIT = 1;
  localparam int ST_XCNT_LSB  = 16;

  localparam logic [31:0] TMO_ERR_WORD = 32'hFFFF_FFFF;

  function automatic logic [31:0] status_word(input logic err,
                                              input logic y_seen,
                                              input logic [15:0] x_cnt);
    logic [31:0] w;
    w = '0;
    w[ST_ERR_BIT]            = err;
    w[ST_YSEEN_BIT]          = y_seen;
    w[ST_XCNT_LSB +: 16]     = x_cnt;
    return w;
  endfunction

endpackage

// File: rtl/fir_wb_tlast_gen.sv
// Tracks the snooped FIR data_length and the X sample count to produce ss_tlast.
module fir_wb_tlast_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        len_wr,
  input  logic [31:0] len_val,
  input  logic        cnt_clr,
  input  logic        push,
  output logic        tlast,
  output logic [15:0] x_cnt_lo
);

  logic [31:0] len_q, len_d;
  logic [31:0] x_cnt_q, x_cnt_d;

  // A zero length never matches, so the counter simply free-runs in that case.
  assign tlast    = (len_q != 32'd0) && (x_cnt_q == (len_q - 32'd1));
  assign x_cnt_lo = x_cnt_q[15:0];

  always_comb begin
    len_d   = len_q;
    x_cnt_d = x_cnt_q;
    if (len_wr) begin
      len_d   = len_val;
      x_cnt_d = '0;
    end else if (cnt_clr) begin
      x_cnt_d = '0;
    end else if (push) begin
      x_cnt_d = tlast ? 32'd0 : x_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      x_cnt_q <= '0;
    end else begin
      len_q   <= len_d;
      x_cnt_q <= x_cnt_d;
    end
  end

endmodule

// File: rtl/fir_wb_sched.sv
// Wishbone slave that serialises CPU accesses onto the FIR AXI-Lite/AXI-Stream ports.
// Optional wait timeout is enabled with `define FIR_WB_TIMEOUT_EN.
module fir_wb_sched
  import fir_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        awvalid,
  input  logic        awready,
  output logic [11:0] awaddr,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic        arvalid,
  input  logic        arready,
  output logic [11:0] araddr,
  output logic        rready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  output logic        ss_tvalid,
  output logic        ss_tlast,
  output logic [31:0] ss_tdata,
  input  logic        ss_tready,
  input  logic        sm_tvalid,
  input  logic        sm_tlast,
  input  logic [31:0] sm_tdata,
  output logic        sm_tready
);

  localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
`ifdef FIR_WB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [7:0]          off_q, off_d;
  logic [31:0]         dat_q, dat_d;
  logic [31:0]         ack_dat_q, ack_dat_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                ar_done_q, ar_done_d;
  logic                y_seen_q, y_seen_d;
  logic                err_q, err_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic        req, waiting, timeout;
  logic        aw_hs, w_hs, ar_hs, r_hs, ss_hs, sm_hs;
  logic        len_wr, cnt_clr, tlast_raw;
  logic [15:0] x_cnt_lo;
  logic        sel_unused;

  assign sel_unused = ^wbs_sel_i;

  assign req     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign waiting = state_q inside {CFG_WR, CFG_RD, X_PUSH, Y_POP};
  assign timeout = TMO_EN && waiting && (wait_q == WAIT_W'(TIMEOUT));

  // FIR-side strobes come straight from the state so they rise the cycle after acceptance.
  assign awvalid   = (state_q == CFG_WR) && !aw_done_q && !timeout;
  assign wvalid    = (state_q == CFG_WR) && !w_done_q && !timeout;
  assign arvalid   = (state_q == CFG_RD) && !ar_done_q && !timeout;
  assign rready    = (state_q == CFG_RD) && ar_done_q && !timeout;
  assign ss_tvalid = (state_q == X_PUSH) && !timeout;
  assign ss_tlast  = ss_tvalid && tlast_raw;
  assign ss_tdata  = ss_tvalid ? dat_q : '0;
  assign sm_tready = (state_q == Y_POP) && !timeout;
  assign awaddr    = {4'h0, off_q};
  assign araddr    = {4'h0, off_q};
  assign wdata     = dat_q;
  assign wbs_ack_o = (state_q == ACK);
  assign wbs_dat_o = wbs_ack_o ? ack_dat_q : '0;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rready && rvalid;
  assign ss_hs = ss_tvalid && ss_tready;
  assign sm_hs = sm_tready && sm_tvalid;

  fir_wb_tlast_gen u_tlast (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .len_wr   (len_wr),
    .len_val  (dat_q),
    .cnt_clr  (cnt_clr),
    .push     (ss_hs),
    .tlast    (tlast_raw),
    .x_cnt_lo (x_cnt_lo)
  );

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    dat_d     = dat_q;
    ack_dat_d = ack_dat_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_done_d = ar_done_q;
    y_seen_d  = y_seen_q;
    err_d     = err_q;
    wait_d    = (waiting && !timeout) ? wait_q + WAIT_W'(1) : '0;
    len_wr    = 1'b0;
    cnt_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        ar_done_d = 1'b0;
        if (req) begin
          off_d     = wbs_adr_i[7:0];
          dat_d     = wbs_dat_i;
          ack_dat_d = '0;
          if (wbs_adr_i[7:0] < X_OFF) begin
            state_d = wbs_we_i ? CFG_WR : CFG_RD;
          end else if ((wbs_adr_i[7:0] == X_OFF) && wbs_we_i) begin
            state_d = X_PUSH;
          end else if ((wbs_adr_i[7:0] == Y_OFF) && !wbs_we_i) begin
            state_d = Y_POP;
          end else if ((wbs_adr_i[7:0] == ST_OFF) && !wbs_we_i) begin
            ack_dat_d = status_word(err_q, y_seen_q, x_cnt_lo);
            y_seen_d  = 1'b0;
            state_d   = ACK;
          end else begin
            state_d = ACK;
          end
        end
      end

      CFG_WR: begin
        if (timeout) begin
          err_d     = 1'b1;
          ack_dat_d = TMO_ERR_WORD;
          state_d   = ACK;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
          if (aw_done_d && w_done_d) begin
            len_wr  = (off_q == LEN_OFF);
            cnt_clr = (off_q == AP_OFF) && dat_q[0];
            state_d = ACK;
          end
        end
      end

      CFG_RD: begin
        if (timeout) begin
          err_d     = 1'b1;
          ack_dat_d = TMO_ERR_WORD;
          state_d   = ACK;
        end else if (ar_hs) begin
          ar_done_d = 1'b1;
        end else if (r_hs) begin
          ack_dat_d = rdata;
          state_d   = ACK;
        end
      end

      X_PUSH: begin
        if (timeout) begin
          err_d     = 1'b1;
          ack_dat_d = TMO_ERR_WORD;
          state_d   = ACK;
        end else if (ss_hs) begin
          state_d = ACK;
        end
      end

      Y_POP: begin
        if (timeout) begin
          err_d     = 1'b1;
          ack_dat_d = TMO_ERR_WORD;
          state_d   = ACK;
        end else if (sm_hs) begin
          ack_dat_d = sm_tdata;
          if (sm_tlast) y_seen_d = 1'b1;
          state_d = ACK;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      off_q     <= '0;
      dat_q     <= '0;
      ack_dat_q <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
      y_seen_q  <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      dat_q     <= dat_d;
      ack_dat_q <= ack_dat_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
      y_seen_q  <= y_seen_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
    end
  end

endmodule
